// File: rtl/cache_pkg.sv
// Shared types for the cache request arbiter: controller operation codes,
// arbiter FSM states and a one-hot to index helper.
package cache_pkg;

    typedef enum logic [1:0] {
        NOOP  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } operation_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    localparam int NUM_ENTRIES = 256;
    localparam int MAX_REQ     = 16;

    // Index of the set bit in a one-hot vector; a zero vector maps to 0.
    function automatic logic [3:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_req_arbiter_rr_pick.sv
// Round-robin pick: first set bit of mask_i scanning up from ptr_i with
// wrap-around, returned as a one-hot grant.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             any_valid_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr_i) + k) % N;
            if (!found && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign any_valid_o = |mask_i;

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one single-ported cache controller between
// NUM_REQ clients: accept, issue one-cycle op, wait for ready or timeout, respond.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = 16,
    parameter int VAL_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0][1:0]         req_op_i,
    input  logic [NUM_REQ-1:0][KEY_W-1:0]   req_key_i,
    input  logic [NUM_REQ-1:0][VAL_W-1:0]   req_val_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [VAL_W-1:0]                rsp_data_o,
    output logic                            rsp_hit_o,
    output logic                            rsp_err_o,
    output logic [1:0]                      cache_op_o,
    output logic [KEY_W-1:0]                cache_key_o,
    output logic [VAL_W-1:0]                cache_val_o,
    input  logic                            cache_ready_i,
    input  logic [VAL_W-1:0]                cache_data_i,
    input  logic                            cache_hit_i,
    output logic                            busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         state_q;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q;
    logic [7:0]         timer_q;
    operation_e         op_q;
    logic [KEY_W-1:0]   key_q;
    logic [VAL_W-1:0]   val_q;
    logic [VAL_W-1:0]   data_q;
    logic               hit_q;
    logic               err_q;
    logic [1:0]         cache_op_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic               any_valid;
    logic [PTR_W-1:0]   win_idx;

    // A client asking for NOOP is masked out entirely.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && (req_op_i[i] != NOOP);
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .mask_i      (elig),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    assign win_idx  = PTR_W'(oh_to_idx(MAX_REQ'(grant)));
    assign rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            timer_q     <= '0;
            op_q        <= NOOP;
            key_q       <= '0;
            val_q       <= '0;
            data_q      <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            cache_op_q  <= NOOP;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        op_q       <= operation_e'(req_op_i[win_idx]);
                        key_q      <= req_key_i[win_idx];
                        val_q      <= req_val_i[win_idx];
                        owner_q    <= win_idx;
                        cache_op_q <= req_op_i[win_idx];
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cache_op_q <= NOOP;
                    timer_q    <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (cache_ready_i) begin
                        data_q      <= (op_q == READ) ? cache_data_i : '0;
                        hit_q       <= cache_hit_i;
                        err_q       <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else if (timer_q == 8'(TIMEOUT - 1)) begin
                        data_q      <= '0;
                        hit_q       <= 1'b0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= NUM_REQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    data_q      <= '0;
                    hit_q       <= 1'b0;
                    err_q       <= 1'b0;
                    rr_ptr_q    <= rr_ptr_d;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE) ? grant : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = data_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_err_o   = err_q;
    assign cache_op_o  = cache_op_q;
    assign cache_key_o = key_q;
    assign cache_val_o = val_q;
    assign busy_o      = busy_q;

endmodule
